// File: rtl/tsp_result_checker.sv
// Receive-side checker for the two-stage add/sub pipeline: each issued expected value is
// delayed LATENCY cycles and compared against the observed pipeline result.
module tsp_result_checker #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CWIDTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              issue_valid,
  input  logic [DWIDTH-1:0] issue_exp,
  input  logic [DWIDTH-1:0] res,
  output logic              busy,
  output logic              mismatch,
  output logic              fail,
  output logic [DWIDTH-1:0] got,
  output logic [DWIDTH-1:0] exp_last,
  output logic [CWIDTH-1:0] pass_cnt,
  output logic [CWIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FAIL   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LATENCY-1:0] v_q, v_d;
  logic [DWIDTH-1:0]  e_q [LATENCY];
  logic [DWIDTH-1:0]  e_d [LATENCY];
  logic [CWIDTH-1:0]  pass_q, pass_d, err_q, err_d;
  logic [DWIDTH-1:0]  got_q, got_d, expl_q, expl_d;
  logic               mis_q, mis_d;

  logic cmp_en, cmp_bad;

  assign cmp_en  = v_q[LATENCY-1];
  // Case inequality so that any X/Z bit on res is reported as a failure.
  assign cmp_bad = cmp_en && (res !== e_q[LATENCY-1]);

  always_comb begin
    v_d    = v_q;
    e_d    = e_q;
    pass_d = pass_q;
    err_d  = err_q;
    got_d  = got_q;
    expl_d = expl_q;
    mis_d  = 1'b0;
    if (clear) begin
      v_d    = '0;
      pass_d = '0;
      err_d  = '0;
      got_d  = '0;
      expl_d = '0;
    end else begin
      v_d[0] = issue_valid;
      e_d[0] = issue_exp;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        v_d[i] = v_q[i-1];
        e_d[i] = e_q[i-1];
      end
      if (cmp_bad) begin
        if (err_q != '1) err_d = err_q + 1'b1;
        got_d  = res;
        expl_d = e_q[LATENCY-1];
        mis_d  = 1'b1;
      end else if (cmp_en) begin
        if (pass_q != '1) pass_d = pass_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= '0;
      e_q    <= '{default: '0};
      pass_q <= '0;
      err_q  <= '0;
      got_q  <= '0;
      expl_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      v_q    <= v_d;
      e_q    <= e_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      got_q  <= got_d;
      expl_q <= expl_d;
      mis_q  <= mis_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (issue_valid) state_d = S_ACTIVE;
        S_ACTIVE: begin
          if (cmp_bad)         state_d = S_FAIL;
          else if (v_d == '0)  state_d = S_IDLE;
        end
        S_FAIL:   state_d = S_FAIL;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fail     = (state_q == S_FAIL);
    busy     = |v_q;
    mismatch = mis_q;
    got      = got_q;
    exp_last = expl_q;
    pass_cnt = pass_q;
    err_cnt  = err_q;
  end

endmodule

// File: tb/tb_tsp_result_checker.sv
// Bench for tsp_result_checker: two instances (L=2/CW=16/DW=32 and L=3/CW=2/DW=8) share one
// issue stream; a timestamped history model predicts every output on every cycle.
module tb_tsp_result_checker;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        iv    = 1'b0;
  logic [31:0] ie    = '0;
  logic [31:0] res0  = '0;
  logic [7:0]  res1  = '0;

  logic        busy0, mis0, fail0;
  logic [31:0] got0, expl0;
  logic [15:0] pass0, err0;
  logic        busy1, mis1, fail1;
  logic [7:0]  got1, expl1;
  logic [1:0]  pass1, err1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tsp_result_checker #(.DWIDTH(32), .LATENCY(2), .CWIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .issue_valid(iv), .issue_exp(ie), .res(res0),
    .busy(busy0), .mismatch(mis0), .fail(fail0), .got(got0), .exp_last(expl0),
    .pass_cnt(pass0), .err_cnt(err0)
  );

  tsp_result_checker #(.DWIDTH(8), .LATENCY(3), .CWIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .issue_valid(iv), .issue_exp(ie[7:0]), .res(res1),
    .busy(busy1), .mismatch(mis1), .fail(fail1), .got(got1), .exp_last(expl1),
    .pass_cnt(pass1), .err_cnt(err1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model: history of issues keyed by edge number ----------------
  int unsigned lat  [2] = '{2, 3};
  int unsigned cmax [2] = '{65535, 3};
  logic        hv [2][16];
  logic [31:0] he [2][16];
  int unsigned m_pass [2];
  int unsigned m_err  [2];
  logic        m_fail [2];
  logic        m_mis  [2];
  logic [31:0] m_got  [2];
  logic [31:0] m_expl [2];
  int unsigned mcyc = 0;

  always @(posedge clk) begin
    logic        s_iv, s_clr, s_rst, m_busy;
    logic [31:0] s_e [2];
    logic [31:0] s_r [2];
    int unsigned old;
    s_iv  = iv;
    s_clr = clear;
    s_rst = reset;
    s_e[0] = ie;
    s_e[1] = {24'b0, ie[7:0]};
    s_r[0] = res0;
    s_r[1] = {24'b0, res1};
    for (int k = 0; k < 2; k++) begin
      if (s_rst || s_clr) begin
        for (int j = 0; j < 16; j++) hv[k][j] = 1'b0;
        m_pass[k] = 0; m_err[k] = 0; m_fail[k] = 1'b0; m_mis[k] = 1'b0;
        m_got[k] = '0; m_expl[k] = '0;
      end else begin
        m_mis[k] = 1'b0;
        old = (mcyc + 16 - lat[k]) % 16;
        if (hv[k][old]) begin
          hv[k][old] = 1'b0;
          if (s_r[k] === he[k][old]) begin
            if (m_pass[k] < cmax[k]) m_pass[k]++;
          end else begin
            if (m_err[k] < cmax[k]) m_err[k]++;
            m_got[k] = s_r[k]; m_expl[k] = he[k][old];
            m_fail[k] = 1'b1; m_mis[k] = 1'b1;
          end
        end
        if (s_iv) begin
          hv[k][mcyc % 16] = 1'b1;
          he[k][mcyc % 16] = s_e[k];
        end
      end
    end
    mcyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_busy = 1'b0;
      for (int j = 0; j < 16; j++) m_busy = m_busy | hv[k][j];
      chk($sformatf("busy%0d", k),     (k == 0) ? {31'b0, busy0} : {31'b0, busy1}, {31'b0, m_busy});
      chk($sformatf("mismatch%0d", k), (k == 0) ? {31'b0, mis0}  : {31'b0, mis1},  {31'b0, m_mis[k]});
      chk($sformatf("fail%0d", k),     (k == 0) ? {31'b0, fail0} : {31'b0, fail1}, {31'b0, m_fail[k]});
      chk($sformatf("got%0d", k),      (k == 0) ? got0  : {24'b0, got1},  m_got[k]);
      chk($sformatf("exp_last%0d", k), (k == 0) ? expl0 : {24'b0, expl1}, m_expl[k]);
      chk($sformatf("pass_cnt%0d", k), (k == 0) ? {16'b0, pass0} : {30'b0, pass1}, m_pass[k]);
      chk($sformatf("err_cnt%0d", k),  (k == 0) ? {16'b0, err0}  : {30'b0, err1},  m_err[k]);
    end
  end

  // ---------------- stimulus: res echoes what was issued LATENCY edges earlier ----------------
  logic [31:0] ring [64];
  int unsigned dt = 8;

  task automatic tick(input logic v, input logic [31:0] e, input logic bad);
    logic [31:0] r1;
    iv = v;
    ie = e;
    ring[dt % 64] = e;
    res0 = ring[(dt - 2) % 64] ^ {31'b0, bad};
    r1   = ring[(dt - 3) % 64];
    res1 = r1[7:0] ^ {7'b0, bad};
    @(posedge clk);
    @(negedge clk);
    dt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, 1'b0);
  endtask

  initial begin
    logic [15:0] p_snap, e_snap;
    for (int i = 0; i < 64; i++) ring[i] = $urandom;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: three passes
    tick(1'b1, 32'h2, 1'b0);
    tick(1'b1, 32'h20, 1'b0);
    tick(1'b1, 32'h1, 1'b0);
    idle(3);
    chk("t1_pass0", {16'b0, pass0}, 32'd3);
    chk("t1_err0", {16'b0, err0}, 32'd0);
    chk("t1_fail0", {31'b0, fail0}, 32'd0);
    chk("t1_busy0", {31'b0, busy0}, 32'd0);
    chk("t1_pass1", {30'b0, pass1}, 32'd3);

    // 2: single failure on dut0
    tick(1'b1, 32'h20, 1'b0);
    tick(1'b0, $urandom, 1'b0);
    tick(1'b0, $urandom, 1'b1);
    chk("t2_mis0", {31'b0, mis0}, 32'd1);
    chk("t2_err0", {16'b0, err0}, 32'd1);
    chk("t2_got0", got0, 32'h21);
    chk("t2_expl0", expl0, 32'h20);
    chk("t2_fail0", {31'b0, fail0}, 32'd1);
    tick(1'b0, $urandom, 1'b0);
    chk("t2_mis0_pulse", {31'b0, mis0}, 32'd0);
    chk("t2_fail0_sticky", {31'b0, fail0}, 32'd1);

    // 3: no issues, random res
    p_snap = pass0;
    e_snap = err0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, $urandom, 1'($urandom_range(0, 1)));
      chk("t3_mis0", {31'b0, mis0}, 32'd0);
    end
    chk("t3_pass0", {16'b0, pass0}, {16'b0, p_snap});
    chk("t3_err0", {16'b0, err0}, {16'b0, e_snap});
    chk("t3_busy0", {31'b0, busy0}, 32'd0);

    // 4: clear wins over a pending check and a same-cycle issue
    tick(1'b1, 32'h55, 1'b0);
    clear = 1'b1;
    tick(1'b1, 32'h66, 1'b0);
    clear = 1'b0;
    chk("t4_busy0", {31'b0, busy0}, 32'd0);
    chk("t4_fail0", {31'b0, fail0}, 32'd0);
    tick(1'b0, $urandom, 1'b0);
    tick(1'b0, $urandom, 1'b0);
    chk("t4_pass0", {16'b0, pass0}, 32'd0);
    chk("t4_err0", {16'b0, err0}, 32'd0);
    chk("t4_pass1", {30'b0, pass1}, 32'd0);
    chk("t4_busy1", {31'b0, busy1}, 32'd0);

    // random phase
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      tick(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 4) == 0));
      clear = 1'b0;
    end

    // 5: asynchronous reset with two checks pending
    tick(1'b1, $urandom, 1'b0);
    tick(1'b1, $urandom, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy0", {31'b0, busy0}, 32'd0);
    chk("t5_pass0", {16'b0, pass0}, 32'd0);
    chk("t5_err0", {16'b0, err0}, 32'd0);
    chk("t5_fail0", {31'b0, fail0}, 32'd0);
    chk("t5_got0", got0, 32'd0);
    chk("t5_busy1", {31'b0, busy1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dt++;
    idle(3);
    chk("t5_late_pass0", {16'b0, pass0}, 32'd0);
    chk("t5_late_err0", {16'b0, err0}, 32'd0);
    chk("t5_late_pass1", {30'b0, pass1}, 32'd0);
    chk("t5_late_err1", {30'b0, err1}, 32'd0);

    // 6: 2-bit counters saturate; failure still recorded
    for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0);
    idle(4);
    chk("t6_pass1_sat", {30'b0, pass1}, 32'd3);
    chk("t6_err1", {30'b0, err1}, 32'd0);
    chk("t6_fail1", {31'b0, fail1}, 32'd0);
    chk("t6_busy1", {31'b0, busy1}, 32'd0);
    tick(1'b1, 32'h3c, 1'b0);
    tick(1'b0, $urandom, 1'b0);
    tick(1'b0, $urandom, 1'b0);
    tick(1'b0, $urandom, 1'b1);
    chk("t6_mis1", {31'b0, mis1}, 32'd1);
    chk("t6_err1_after", {30'b0, err1}, 32'd1);
    chk("t6_fail1_after", {31'b0, fail1}, 32'd1);
    chk("t6_got1", {24'b0, got1}, 32'h3d);
    chk("t6_expl1", {24'b0, expl1}, 32'h3c);
    chk("t6_pass1_held", {30'b0, pass1}, 32'd3);
    idle(1);
    chk("t6_mis1_pulse", {31'b0, mis1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
